// File: rtl/matrix_result_collector_pkg.sv
// rtl/matrix_result_collector_pkg.sv - shared sizes, bank states and element clamp for the result collector
// Contents:
//   S2P_SIZE     results per row, also rows per tile
//   RESULT_SIZE  bits per signed result
//   ROW_W        bits per packed row
//   IDX_W        row index width
//   CNT_W        row count width (holds 0..S2P_SIZE)
//   bank_state_e ping-pong bank lifecycle
//   relu_clamp   negative element -> 0
package matrix_result_collector_pkg;

   localparam int S2P_SIZE    = 4;
   localparam int RESULT_SIZE = 32;
   localparam int ROW_W       = S2P_SIZE * RESULT_SIZE;
   localparam int IDX_W       = (S2P_SIZE > 1) ? $clog2(S2P_SIZE) : 1;
   localparam int CNT_W       = $clog2(S2P_SIZE + 1);

   typedef enum logic [1:0] {
      BANK_EMPTY    = 2'd0,
      BANK_FILLING  = 2'd1,
      BANK_FULL     = 2'd2,
      BANK_DRAINING = 2'd3
   } bank_state_e;

   function automatic logic [RESULT_SIZE-1:0] relu_clamp(input logic [RESULT_SIZE-1:0] v);
      return v[RESULT_SIZE-1] ? '0 : v;
   endfunction

endpackage

// File: rtl/matrix_result_collector_result_bank.sv
// rtl/matrix_result_collector_result_bank.sv - one tile bank: row storage, stored count, lifecycle state
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   wr_en/wr_idx/wr_data   row write port
//   close/close_cnt        tile complete; latch its row count
//   start_drain            FULL -> DRAINING
//   free_bank              DRAINING -> EMPTY (last row accepted)
//   rd_idx/rd_data         row read port (combinational)
//   count                  stored row count of the closed tile
//   state                  current bank state
module result_bank
   import matrix_result_collector_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [ROW_W-1:0] wr_data,
   input  logic             close,
   input  logic [CNT_W-1:0] close_cnt,
   input  logic             start_drain,
   input  logic             free_bank,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [ROW_W-1:0] rd_data,
   output logic [CNT_W-1:0] count,
   output bank_state_e      state
);

   bank_state_e      state_nxt;
   logic [ROW_W-1:0] mem [S2P_SIZE];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= BANK_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // A single-row tile closes straight from EMPTY, so close wins over wr_en.
   always_comb begin
      state_nxt = state;
      case (state)
         BANK_EMPTY: begin
            if (close)      state_nxt = BANK_FULL;
            else if (wr_en) state_nxt = BANK_FILLING;
         end
         BANK_FILLING: begin
            if (close) state_nxt = BANK_FULL;
         end
         BANK_FULL: begin
            if (start_drain) state_nxt = BANK_DRAINING;
         end
         BANK_DRAINING: begin
            if (free_bank) state_nxt = BANK_EMPTY;
         end
         default: state_nxt = BANK_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < S2P_SIZE; i++) begin
            mem[i] <= '0;
         end
         count <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_idx] <= wr_data;
         end
         if (close) begin
            count <= close_cnt;
         end
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/matrix_result_collector.sv
// rtl/matrix_result_collector.sv - ping-pong tile assembler and row streamer for multiplier results
// Optional feature macro: RESULT_RELU_EN (clamp negative elements to 0 at capture)
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_row     product row, element k at [ROW_W-1-k*RESULT_SIZE -: RESULT_SIZE]
//   in_done    [0] row valid pulse, [1] last row of tile (with [0])
//   tile_req   one-cycle pulse requesting the next tile
//   out_data   row being drained, same packing as in_row
//   out_valid  out_data valid
//   out_ready  downstream accept
//   out_last   final row of the tile
//   err_ovf    sticky: row dropped, no bank could take it
//   err_seq    sticky: tile closed with row count != S2P_SIZE
module matrix_result_collector
   import matrix_result_collector_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [ROW_W-1:0] in_row,
   input  logic [1:0]       in_done,
   output logic             tile_req,
   output logic [ROW_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             err_ovf,
   output logic             err_seq
);

   logic             wr_ptr;
   logic             rd_ptr;
   logic [CNT_W-1:0] wr_cnt;
   logic [CNT_W-1:0] rd_cnt;
   logic             in_flight;

   logic [ROW_W-1:0] wr_row;
   logic             can_write;
   logic             row_accept;
   logic             row_drop;
   logic             tile_close;
   logic [CNT_W-1:0] close_cnt;
   logic             req_cond;
   logic             beat_accept;
   logic             last_accept;
   logic             next_rd_ptr;
   logic [CNT_W-1:0] rd_count;

   logic [1:0]       bank_wr_en;
   logic [1:0]       bank_close;
   logic [1:0]       bank_start_drain;
   logic [1:0]       bank_free;
   logic [ROW_W-1:0] bank_rd_data [2];
   logic [CNT_W-1:0] bank_count [2];
   bank_state_e      bank_state [2];

   always_comb begin
      wr_row = in_row;
`ifdef RESULT_RELU_EN
      for (int k = 0; k < S2P_SIZE; k++) begin
         wr_row[ROW_W-1-k*RESULT_SIZE -: RESULT_SIZE] =
            relu_clamp(in_row[ROW_W-1-k*RESULT_SIZE -: RESULT_SIZE]);
      end
`endif
   end

   // Write side. A full-count bank keeps FILLING and drops extra rows; a late
   // last-row marker still closes it so the pipeline cannot lock up.
   assign can_write  = (bank_state[wr_ptr] == BANK_EMPTY) || (bank_state[wr_ptr] == BANK_FILLING);
   assign row_accept = in_done[0] && can_write && (wr_cnt != CNT_W'(S2P_SIZE));
   assign row_drop   = in_done[0] && !row_accept;
   assign tile_close = in_done[0] && in_done[1] && can_write;
   assign close_cnt  = row_accept ? (wr_cnt + CNT_W'(1)) : wr_cnt;

   assign req_cond = !in_flight && (bank_state[wr_ptr] == BANK_EMPTY);

   // Read side.
   assign rd_count    = bank_count[rd_ptr];
   assign out_valid   = (bank_state[rd_ptr] == BANK_DRAINING);
   assign out_last    = out_valid && (rd_cnt == (rd_count - CNT_W'(1)));
   assign out_data    = out_valid ? bank_rd_data[rd_ptr] : '0;
   assign beat_accept = out_valid && out_ready;
   assign last_accept = beat_accept && out_last;
   // Looking at the post-accept read pointer lets the other FULL bank start
   // draining on the same edge the current one frees, so no bubble appears.
   assign next_rd_ptr = rd_ptr ^ last_accept;

   for (genvar g = 0; g < 2; g++) begin : g_bank
      assign bank_wr_en[g]       = row_accept && (wr_ptr == 1'(g));
      assign bank_close[g]       = tile_close && (wr_ptr == 1'(g));
      assign bank_free[g]        = last_accept && (rd_ptr == 1'(g));
      assign bank_start_drain[g] = (bank_state[g] == BANK_FULL) && (next_rd_ptr == 1'(g));

      result_bank u_bank (
         .clk         (clk),
         .rst         (rst),
         .wr_en       (bank_wr_en[g]),
         .wr_idx      (wr_cnt[IDX_W-1:0]),
         .wr_data     (wr_row),
         .close       (bank_close[g]),
         .close_cnt   (close_cnt),
         .start_drain (bank_start_drain[g]),
         .free_bank   (bank_free[g]),
         .rd_idx      (rd_cnt[IDX_W-1:0]),
         .rd_data     (bank_rd_data[g]),
         .count       (bank_count[g]),
         .state       (bank_state[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         wr_cnt    <= '0;
         rd_cnt    <= '0;
         in_flight <= 1'b0;
         tile_req  <= 1'b0;
         err_ovf   <= 1'b0;
         err_seq   <= 1'b0;
      end else begin
         if (tile_close) begin
            wr_cnt <= '0;
            wr_ptr <= ~wr_ptr;
         end else if (row_accept) begin
            wr_cnt <= wr_cnt + CNT_W'(1);
         end

         if (beat_accept) begin
            rd_cnt <= last_accept ? '0 : (rd_cnt + CNT_W'(1));
         end
         if (last_accept) begin
            rd_ptr <= ~rd_ptr;
         end

         tile_req <= req_cond;
         if (req_cond) begin
            in_flight <= 1'b1;
         end else if (tile_close) begin
            in_flight <= 1'b0;
         end

         if (row_drop) begin
            err_ovf <= 1'b1;
         end
         if (tile_close && (close_cnt != CNT_W'(S2P_SIZE))) begin
            err_seq <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_matrix_result_collector.sv
// tb/tb_matrix_result_collector.sv - directed self-checking bench for matrix_result_collector
module tb_matrix_result_collector;

   logic         clk;
   logic         rst;
   logic [127:0] in_row;
   logic [1:0]   in_done;
   logic         tile_req;
   logic [127:0] out_data;
   logic         out_valid;
   logic         out_ready;
   logic         out_last;
   logic         err_ovf;
   logic         err_seq;

   int passed = 0;
   int total  = 0;

   matrix_result_collector dut (
      .clk       (clk),
      .rst       (rst),
      .in_row    (in_row),
      .in_done   (in_done),
      .tile_req  (tile_req),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .err_ovf   (err_ovf),
      .err_seq   (err_seq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [127:0] mk_row(input logic [31:0] b);
      return {b, b + 32'd1, b + 32'd2, b + 32'd3};
   endfunction

   task automatic send_row(input logic [127:0] row, input logic [1:0] done);
      in_row  = row;
      in_done = done;
      tick();
      in_done = 2'b00;
      in_row  = '0;
   endtask

   int rdy [6] = '{1, 0, 0, 1, 1, 1};
   int exi [6] = '{0, 1, 1, 1, 2, 3};
   logic [127:0] neg_row;
   logic [127:0] neg_exp;

   initial begin
      rst       = 1'b1;
      in_row    = '0;
      in_done   = 2'b00;
      out_ready = 1'b0;
      tick();
      tick();
      chk("rst_tile_req", tile_req, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_err_ovf", err_ovf, 0);
      chk("rst_err_seq", err_seq, 0);

      // 1: single tile_req pulse after reset release
      rst = 1'b0;
      tick();
      chk("t1_req_pulse", tile_req, 1);
      chk("t1_out_valid", out_valid, 0);
      tick();
      chk("t1_req_once", tile_req, 0);

      // 2: one full tile, element k of row r = 16r+k
      out_ready = 1'b1;
      for (int r = 0; r < 4; r++) begin
         send_row(mk_row(32'(16 * r)), (r == 3) ? 2'b11 : 2'b01);
      end
      chk("t2_latency", out_valid, 0);
      tick();
      chk("t2_next_req", tile_req, 1);
      for (int b = 0; b < 4; b++) begin
         chk("t2_valid", out_valid, 1);
         chk("t2_data", out_data, mk_row(32'(16 * b)));
         chk("t2_last", out_last, (b == 3) ? 1 : 0);
         if (b == 1) chk("t2_row1_lit", out_data, 128'h00000010_00000011_00000012_00000013);
         tick();
      end
      chk("t2_done", out_valid, 0);
      chk("t2_err_seq", err_seq, 0);

      // 3: two tiles held back, a 9th row overflows, then 8 beats with no bubble
      out_ready = 1'b0;
      for (int r = 0; r < 4; r++) send_row(mk_row(32'h100 + 32'(16 * r)), (r == 3) ? 2'b11 : 2'b01);
      for (int r = 0; r < 4; r++) send_row(mk_row(32'h200 + 32'(16 * r)), (r == 3) ? 2'b11 : 2'b01);
      chk("t3_no_ovf_yet", err_ovf, 0);
      send_row(mk_row(32'h900), 2'b01);
      chk("t3_err_ovf", err_ovf, 1);
      chk("t3_stall_valid", out_valid, 1);
      chk("t3_stall_data", out_data, mk_row(32'h100));
      out_ready = 1'b1;
      for (int b = 0; b < 8; b++) begin
         chk("t3_valid", out_valid, 1);
         chk("t3_data", out_data, (b < 4) ? mk_row(32'h100 + 32'(16 * b)) : mk_row(32'h200 + 32'(16 * (b - 4))));
         chk("t3_last", out_last, (b == 3 || b == 7) ? 1 : 0);
         tick();
      end
      chk("t3_done", out_valid, 0);

      // 4: out_ready 1,0,0,1 during a drain
      out_ready = 1'b0;
      for (int r = 0; r < 4; r++) send_row(mk_row(32'h300 + 32'(16 * r)), (r == 3) ? 2'b11 : 2'b01);
      tick();
      for (int i = 0; i < 6; i++) begin
         out_ready = rdy[i][0];
         chk("t4_valid", out_valid, 1);
         chk("t4_data", out_data, mk_row(32'h300 + 32'(16 * exi[i])));
         chk("t4_last", out_last, (exi[i] == 3) ? 1 : 0);
         tick();
      end
      chk("t4_done", out_valid, 0);

      // 5: short tile of 2 rows
      out_ready = 1'b0;
      send_row(mk_row(32'h500), 2'b01);
      chk("t5_seq_clear", err_seq, 0);
      send_row(mk_row(32'h510), 2'b11);
      chk("t5_err_seq", err_seq, 1);
      out_ready = 1'b1;
      tick();
      chk("t5_b0_data", out_data, mk_row(32'h500));
      chk("t5_b0_last", out_last, 0);
      tick();
      chk("t5_b1_data", out_data, mk_row(32'h510));
      chk("t5_b1_last", out_last, 1);
      tick();
      chk("t5_done", out_valid, 0);

      // 6: negative element handling, then reset in mid-drain
      neg_row = {32'hFFFF_FFF6, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0005};
`ifdef RESULT_RELU_EN
      neg_exp = {32'h0000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0005};
`else
      neg_exp = neg_row;
`endif
      out_ready = 1'b0;
      send_row(neg_row, 2'b01);
      for (int r = 1; r < 4; r++) send_row(mk_row(32'h600 + 32'(16 * r)), (r == 3) ? 2'b11 : 2'b01);
      tick();
      chk("t6_neg_data", out_data, neg_exp);
      out_ready = 1'b1;
      tick();
      chk("t6_row1", out_data, mk_row(32'h610));
      rst = 1'b1;
      tick();
      chk("t6_rst_valid", out_valid, 0);
      chk("t6_rst_ovf", err_ovf, 0);
      chk("t6_rst_seq", err_seq, 0);
      chk("t6_rst_req", tile_req, 0);
      rst = 1'b0;
      tick();
      chk("t6_req_again", tile_req, 1);
      chk("t6_no_valid", out_valid, 0);
      repeat (3) tick();
      chk("t6_no_stale", out_valid, 0);
      chk("t6_no_stale_data", out_data, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
